mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 232 +++++++++++++++++++++++
 tb/tb_mem_responder.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Byte-wide memory responder: a RAM plus an IO window that fronts a TX byte FIFO
// (controller -> sink) and an RX byte FIFO (source -> controller).

module mem_responder_fifo_chk #(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3,
    parameter int CNT_W = 4
) (
    input logic             clk,
    input logic             reset,
    input logic [PTR_W-1:0] wr_ptr,
    input logic [PTR_W-1:0] rd_ptr,
    input logic [CNT_W-1:0] count,
    input logic             push,
    input logic             pop,
    input logic             full,
    input logic             empty
);
    a_count_bound: assert property (@(posedge clk) disable iff (!reset)
        count <= CNT_W'(DEPTH));

    // Pointer distance must agree with occupancy modulo the depth
    a_ptr_gap: assert property (@(posedge clk) disable iff (!reset)
        (wr_ptr - rd_ptr) == count[PTR_W-1:0]);

    a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
        push |-> (!full || pop));

    a_no_underflow: assert property (@(posedge clk) disable iff (!reset)
        pop |-> !empty);
endmodule

module mem_responder_fifo #(
    parameter int DEPTH = 8,
    parameter int PTR_W = $clog2(DEPTH),
    parameter int CNT_W = PTR_W + 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push_i,
    input  logic       pop_i,
    input  logic [7:0] data_i,
    output logic [7:0] data_o,
    output logic       empty_o,
    output logic       full_o
);
    logic [7:0]       buf_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] rd_ptr_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Pointer and occupancy next-state; pointers wrap naturally at the power-of-two depth
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1'b1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_i) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1'b1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + CNT_W'(1'b1);
            2'b01:   count_d = count_q - CNT_W'(1'b1);
            default: count_d = count_q;
        endcase
    end

    // Control state register
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Byte storage; stale entries are harmless since reset clears the pointers
    always_ff @(posedge clk) begin
        if (reset && push_i) begin
            buf_q[wr_ptr_q] <= data_i;
        end
    end

    assign data_o  = buf_q[rd_ptr_q];
    assign empty_o = (count_q == {CNT_W{1'b0}});
    assign full_o  = (count_q == CNT_W'(DEPTH));

    mem_responder_fifo_chk #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W),
        .CNT_W (CNT_W)
    ) u_chk (
        .clk    (clk),
        .reset  (reset),
        .wr_ptr (wr_ptr_q),
        .rd_ptr (rd_ptr_q),
        .count  (count_q),
        .push   (push_i),
        .pop    (pop_i),
        .full   (full_o),
        .empty  (empty_o)
    );
endmodule

module mem_responder #(
    parameter int          ADDR_WIDTH = 17,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] IO_BASE    = 32'h0003_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] mem_a,
    input  logic        mem_wr,
    input  logic [7:0]  mem_dout,
    output logic [7:0]  mem_din,
    output logic        io_buffer_full,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready
);
    localparam int RAM_DEPTH = 1 << ADDR_WIDTH;

    logic [7:0]            ram_q [RAM_DEPTH];
    logic [ADDR_WIDTH-1:0] ram_idx_s;
    logic                  io_sel_s;
    logic                  io_data_s;
    logic [7:0]            mem_din_q;
    logic [7:0]            mem_din_d;

    logic                  tx_push_s;
    logic                  tx_pop_s;
    logic                  tx_empty_s;
    logic                  tx_full_s;
    logic                  rx_push_s;
    logic                  rx_pop_s;
    logic                  rx_empty_s;
    logic                  rx_full_s;
    logic [7:0]            rx_head_s;

    assign io_sel_s  = (mem_a[17:16] == 2'b11);
    assign io_data_s = io_sel_s && (mem_a == IO_BASE);
    assign ram_idx_s = mem_a[ADDR_WIDTH-1:0];

    // A push into a full TX FIFO is only accepted when the sink frees a slot the same cycle
    assign tx_pop_s  = !tx_empty_s && tx_ready;
    assign tx_push_s = io_data_s && mem_wr && (!tx_full_s || tx_pop_s);
    assign rx_push_s = rx_valid && !rx_full_s;
    assign rx_pop_s  = io_data_s && !mem_wr && !rx_empty_s;

    // Read-data next-state; the status byte reflects flags before this cycle's updates
    always_comb begin
        mem_din_d = mem_din_q;
        if (!io_sel_s) begin
            if (mem_wr) begin
                mem_din_d = mem_din_q;
            end else begin
                mem_din_d = ram_q[ram_idx_s];
            end
        end else if (mem_wr) begin
            mem_din_d = mem_din_q;
        end else begin
            case (mem_a)
                IO_BASE:         mem_din_d = rx_empty_s ? 8'h00 : rx_head_s;
                IO_BASE + 32'd4: mem_din_d = {6'b000000, !rx_empty_s, tx_full_s};
                default:         mem_din_d = 8'h00;
            endcase
        end
    end

    // Read-data register
    always_ff @(posedge clk) begin
        if (!reset) begin
            mem_din_q <= 8'h00;
        end else begin
            mem_din_q <= mem_din_d;
        end
    end

    // RAM array; not cleared by reset, but writes are suppressed while reset is asserted
    always_ff @(posedge clk) begin
        if (reset && mem_wr && !io_sel_s) begin
            ram_q[ram_idx_s] <= mem_dout;
        end
    end

    mem_responder_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (tx_push_s),
        .pop_i   (tx_pop_s),
        .data_i  (mem_dout),
        .data_o  (tx_data),
        .empty_o (tx_empty_s),
        .full_o  (tx_full_s)
    );

    mem_responder_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_rx_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (rx_push_s),
        .pop_i   (rx_pop_s),
        .data_i  (rx_data),
        .data_o  (rx_head_s),
        .empty_o (rx_empty_s),
        .full_o  (rx_full_s)
    );

    assign mem_din        = mem_din_q;
    assign tx_valid       = !tx_empty_s;
    assign io_buffer_full = tx_full_s;
    assign rx_ready       = !rx_full_s;
endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed scenarios plus randomized traffic
// checked against a queue-based reference model.

module tb_mem_responder;
    localparam int          AW      = 17;
    localparam int          DEPTH   = 8;
    localparam logic [31:0] IO_BASE = 32'h0003_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic [7:0]  mem_dout;
    logic [7:0]  mem_din;
    logic        io_buffer_full;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    byte unsigned ram_m [int];
    byte unsigned txq [$];
    byte unsigned rxq [$];
    logic [7:0]   exp_din;
    bit           din_known;

    always #5 clk = ~clk;

    mem_responder dut (
        .clk            (clk),
        .reset          (reset),
        .mem_a          (mem_a),
        .mem_wr         (mem_wr),
        .mem_dout       (mem_dout),
        .mem_din        (mem_din),
        .io_buffer_full (io_buffer_full),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .rx_ready       (rx_ready)
    );

    // Apply one clock edge's worth of behaviour to the model using the current inputs
    task automatic model_edge();
        int idx;
        bit io;
        bit txp;
        bit rxp;
        bit rxne;
        bit txf;
        if (!reset) begin
            txq.delete();
            rxq.delete();
            exp_din   = 8'h00;
            din_known = 1'b1;
            return;
        end
        io   = (mem_a[17:16] == 2'b11);
        idx  = int'(mem_a[AW-1:0]);
        rxne = (rxq.size() != 0);
        txf  = (txq.size() == DEPTH);
        txp  = tx_ready && (txq.size() != 0);
        rxp  = rx_valid && (rxq.size() != DEPTH);
        if (txp) void'(txq.pop_front());
        if (!io) begin
            if (mem_wr) begin
                ram_m[idx] = mem_dout;
            end else if (ram_m.exists(idx)) begin
                exp_din   = ram_m[idx];
                din_known = 1'b1;
            end else begin
                din_known = 1'b0;
            end
        end else if (mem_wr) begin
            if (mem_a == IO_BASE && (!txf || txp)) txq.push_back(mem_dout);
        end else begin
            din_known = 1'b1;
            if (mem_a == IO_BASE) exp_din = rxne ? rxq.pop_front() : 8'h00;
            else if (mem_a == IO_BASE + 32'd4) exp_din = {6'b000000, rxne, txf};
            else exp_din = 8'h00;
        end
        if (rxp) rxq.push_back(rx_data);
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        mem_wr   = 1'b1;
        mem_a    = IO_BASE + 32'd8;
        mem_dout = 8'h00;
        tx_ready = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        set_idle();
        step();
        step();
        checks++;
        if (tx_valid !== 1'b0) begin failures++; $display("FAIL reset_tx_valid got=%b want=0", tx_valid); end
        checks++;
        if (io_buffer_full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b want=0", io_buffer_full); end
        checks++;
        if (rx_ready !== 1'b1) begin failures++; $display("FAIL reset_rx_ready got=%b want=1", rx_ready); end
        checks++;
        if (mem_din !== 8'h00) begin failures++; $display("FAIL reset_mem_din got=%h want=00", mem_din); end
        reset = 1'b1;
    endtask

    task automatic test_ram();
        set_idle();
        mem_a = 32'h0000_0010; mem_wr = 1'b1; mem_dout = 8'hA5;
        step();
        checks++;
        if (mem_din !== 8'h00) begin failures++; $display("FAIL ram_write_hold got=%h want=00", mem_din); end
        mem_wr = 1'b0;
        step();
        checks++;
        if (mem_din !== 8'hA5) begin failures++; $display("FAIL ram_raw got=%h want=a5", mem_din); end
    endtask

    task automatic test_burst();
        logic [7:0] vals [4];
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
        set_idle();
        for (int i = 0; i < 4; i++) begin
            mem_wr = 1'b1; mem_a = 32'h0000_0100 + 32'(i); mem_dout = vals[i];
            step();
        end
        mem_wr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mem_a = 32'h0000_0100 + 32'(i);
            step();
            checks++;
            if (mem_din !== vals[i]) begin failures++; $display("FAIL burst[%0d] got=%h want=%h", i, mem_din, vals[i]); end
        end
    endtask

    task automatic test_tx_fill();
        logic       want_full;
        logic [7:0] want;
        set_idle();
        mem_wr = 1'b1; mem_a = IO_BASE;
        for (int i = 0; i < 9; i++) begin
            mem_dout = 8'h61 + 8'(i);
            if (i == 0) begin
                checks++;
                if (tx_valid !== 1'b0) begin failures++; $display("FAIL tx_valid_before_push got=%b want=0", tx_valid); end
            end
            step();
            want_full = (i >= 7);
            checks++;
            if (io_buffer_full !== want_full) begin
                failures++; $display("FAIL tx_fill_full[%0d] got=%b want=%b", i, io_buffer_full, want_full);
            end
        end
        set_idle();
        tx_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            want = 8'h61 + 8'(k);
            checks++;
            if (tx_valid !== 1'b1 || tx_data !== want) begin
                failures++; $display("FAIL tx_drain[%0d] valid=%b data=%h want=%h", k, tx_valid, tx_data, want);
            end
            step();
        end
        checks++;
        if (tx_valid !== 1'b0) begin failures++; $display("FAIL tx_drained_empty got=%b want=0", tx_valid); end
    endtask

    task automatic test_tx_wrap();
        logic [7:0] want;
        set_idle();
        mem_wr = 1'b1; mem_a = IO_BASE;
        for (int i = 0; i < 3; i++) begin mem_dout = 8'h70 + 8'(i); step(); end
        set_idle();
        tx_ready = 1'b1;
        for (int i = 0; i < 3; i++) step();
        tx_ready = 1'b0; mem_wr = 1'b1; mem_a = IO_BASE;
        for (int i = 0; i < 8; i++) begin mem_dout = 8'h80 + 8'(i); step(); end
        tx_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            mem_dout = 8'h90 + 8'(j);
            want = 8'h80 + 8'(j);
            checks++;
            if (tx_data !== want) begin failures++; $display("FAIL tx_wrap_head[%0d] got=%h want=%h", j, tx_data, want); end
            step();
            checks++;
            if (io_buffer_full !== 1'b1) begin failures++; $display("FAIL tx_wrap_full[%0d] got=%b want=1", j, io_buffer_full); end
        end
        set_idle();
        tx_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            want = (k < 4) ? 8'h84 + 8'(k) : 8'h90 + 8'(k - 4);
            checks++;
            if (tx_valid !== 1'b1 || tx_data !== want) begin
                failures++; $display("FAIL tx_wrap_drain[%0d] valid=%b data=%h want=%h", k, tx_valid, tx_data, want);
            end
            step();
        end
        checks++;
        if (tx_valid !== 1'b0) begin failures++; $display("FAIL tx_wrap_empty got=%b want=0", tx_valid); end
    endtask

    task automatic test_rx();
        logic [7:0] want;
        logic       want_rdy;
        set_idle();
        rx_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin rx_data = 8'hC0 + 8'(i); step(); end
        rx_valid = 1'b0; mem_wr = 1'b0; mem_a = IO_BASE + 32'd4;
        step();
        checks++;
        if (mem_din !== 8'h02) begin failures++; $display("FAIL rx_status got=%h want=02", mem_din); end
        mem_a = IO_BASE;
        for (int i = 0; i < 4; i++) begin
            step();
            want = (i < 3) ? 8'hC0 + 8'(i) : 8'h00;
            checks++;
            if (mem_din !== want) begin failures++; $display("FAIL rx_read[%0d] got=%h want=%h", i, mem_din, want); end
        end
        rx_valid = 1'b1; rx_data = 8'h5A;
        step();
        checks++;
        if (mem_din !== 8'h00) begin failures++; $display("FAIL rx_push_on_empty_read got=%h want=00", mem_din); end
        rx_valid = 1'b0;
        step();
        checks++;
        if (mem_din !== 8'h5A) begin failures++; $display("FAIL rx_retained got=%h want=5a", mem_din); end
        set_idle();
        rx_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            rx_data = 8'hD0 + 8'(i);
            step();
            want_rdy = (i < 7);
            checks++;
            if (rx_ready !== want_rdy) begin failures++; $display("FAIL rx_fill_ready[%0d] got=%b want=%b", i, rx_ready, want_rdy); end
        end
        rx_valid = 1'b0; mem_wr = 1'b0; mem_a = IO_BASE;
        for (int i = 0; i < 8; i++) begin
            step();
            want = 8'hD0 + 8'(i);
            checks++;
            if (mem_din !== want) begin failures++; $display("FAIL rx_full_drain[%0d] got=%h want=%h", i, mem_din, want); end
        end
        checks++;
        if (rx_ready !== 1'b1) begin failures++; $display("FAIL rx_ready_after_drain got=%b want=1", rx_ready); end
    endtask

    task automatic test_random();
        int          sel;
        logic [31:0] base;
        set_idle();
        for (int i = 0; i < 32; i++) begin
            mem_wr = 1'b1;
            mem_a = ((i < 16) ? 32'h0000_0200 : 32'h0001_0200) + 32'(i % 16);
            mem_dout = 8'($urandom);
            step();
        end
        for (int n = 0; n < 400; n++) begin
            reset    = ($urandom_range(0, 99) != 0);
            tx_ready = 1'($urandom_range(0, 1));
            rx_valid = 1'($urandom_range(0, 1));
            rx_data  = 8'($urandom);
            mem_dout = 8'($urandom);
            base     = $urandom_range(0, 1) ? 32'h0001_0200 : 32'h0000_0200;
            sel      = $urandom_range(0, 9);
            case (sel)
                0, 1, 2: begin mem_wr = 1'b1; mem_a = base + 32'($urandom_range(0, 15)); end
                3, 4:    begin mem_wr = 1'b0; mem_a = base + 32'($urandom_range(0, 15)); end
                5:       begin mem_wr = 1'b1; mem_a = IO_BASE; end
                6:       begin mem_wr = 1'b0; mem_a = IO_BASE; end
                7:       begin mem_wr = 1'b0; mem_a = IO_BASE + 32'd4; end
                8:       begin mem_wr = 1'b1; mem_a = IO_BASE + 32'd8; end
                default: begin mem_wr = 1'b0; mem_a = IO_BASE + 32'd12; end
            endcase
            step();
            if (din_known) begin
                checks++;
                if (mem_din !== exp_din) begin failures++; $display("FAIL rnd_mem_din[%0d] got=%h want=%h", n, mem_din, exp_din); end
            end
            checks++;
            if (tx_valid !== (txq.size() != 0)) begin failures++; $display("FAIL rnd_tx_valid[%0d] got=%b qsize=%0d", n, tx_valid, txq.size()); end
            checks++;
            if (io_buffer_full !== (txq.size() == DEPTH)) begin failures++; $display("FAIL rnd_full[%0d] got=%b qsize=%0d", n, io_buffer_full, txq.size()); end
            checks++;
            if (rx_ready !== (rxq.size() != DEPTH)) begin failures++; $display("FAIL rnd_rx_ready[%0d] got=%b qsize=%0d", n, rx_ready, rxq.size()); end
            if (txq.size() != 0) begin
                checks++;
                if (tx_data !== txq[0]) begin failures++; $display("FAIL rnd_tx_data[%0d] got=%h want=%h", n, tx_data, txq[0]); end
            end
        end
        reset = 1'b1;
    endtask

    task automatic test_reset_mid();
        set_idle();
        mem_wr = 1'b1; mem_a = IO_BASE; rx_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin mem_dout = 8'hE0 + 8'(i); rx_data = 8'hF0 + 8'(i); step(); end
        reset = 1'b0;
        mem_a = 32'h0000_0010; mem_wr = 1'b1; mem_dout = 8'hFF; tx_ready = 1'b1;
        step();
        checks++;
        if (tx_valid !== 1'b0) begin failures++; $display("FAIL mid_reset_tx_valid got=%b want=0", tx_valid); end
        checks++;
        if (io_buffer_full !== 1'b0) begin failures++; $display("FAIL mid_reset_full got=%b want=0", io_buffer_full); end
        checks++;
        if (rx_ready !== 1'b1) begin failures++; $display("FAIL mid_reset_rx_ready got=%b want=1", rx_ready); end
        checks++;
        if (mem_din !== 8'h00) begin failures++; $display("FAIL mid_reset_mem_din got=%h want=00", mem_din); end
        reset = 1'b1;
        set_idle();
        mem_wr = 1'b0; mem_a = 32'h0000_0010;
        step();
        checks++;
        if (mem_din !== 8'hA5) begin failures++; $display("FAIL ram_survives_reset got=%h want=a5", mem_din); end
        mem_a = IO_BASE + 32'd4;
        step();
        checks++;
        if (mem_din !== 8'h00) begin failures++; $display("FAIL mid_reset_status got=%h want=00", mem_din); end
        mem_a = IO_BASE;
        step();
        checks++;
        if (mem_din !== 8'h00) begin failures++; $display("FAIL mid_reset_rx_discard got=%h want=00", mem_din); end
    endtask

    initial begin
        reset     = 1'b0;
        din_known = 1'b0;
        exp_din   = 8'h00;
        set_idle();
        test_reset();
        test_ram();
        test_burst();
        test_tx_fill();
        test_tx_wrap();
        test_rx();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
